// File: rtl/test_status_port.sv
// Status-code output stage: a small FIFO feeds a hold-timer FSM that drives each
// code on the pad group long enough for an off-chip monitor to observe it.
module test_status_port #(
  parameter int WIDTH       = 5,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic             flush,
  input  logic             code_valid,
  input  logic [WIDTH-1:0] code_data,
  output logic             code_ready,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             busy,
  output logic [7:0]       shown_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [HOLD_W-1:0] hold_cnt;
  logic              full, empty, push, pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign code_ready = ~full;
  assign push       = code_valid & code_ready & ~flush;
  assign busy       = (state == HOLD) | ~empty;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (!empty) pop = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Flush wins over any pop decided above.
    if (flush) begin
      pop        = 1'b0;
      state_next = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= code_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      io_out      <= '1;
      io_oeb      <= '1;
      hold_cnt    <= '0;
      shown_count <= '0;
    end else begin
      io_oeb <= {WIDTH{~enable}};
      if (pop) begin
        io_out      <= mem[rd_ptr];
        hold_cnt    <= HOLD_W'(HOLD_CYCLES - 1);
        shown_count <= shown_count + 8'd1;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_test_status_port.sv
// Self-checking bench for test_status_port: a queue-based reference model is
// compared every cycle, plus literal expectations for the key scenarios.
module tb_test_status_port;

  localparam int W    = 5;
  localparam int D    = 4;
  localparam int HOLD = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         flush = 1'b0;
  logic         code_valid = 1'b0;
  logic [W-1:0] code_data = '0;
  logic         code_ready;
  logic [W-1:0] io_out, io_oeb;
  logic         busy;
  logic [7:0]   shown_count;

  int checks = 0;
  int errors = 0;

  test_status_port #(.WIDTH(W), .DEPTH(D), .HOLD_CYCLES(HOLD)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .enable     (enable),
    .flush      (flush),
    .code_valid (code_valid),
    .code_data  (code_data),
    .code_ready (code_ready),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .busy       (busy),
    .shown_count(shown_count)
  );

  always #5 clk = ~clk;

  // Reference model: queued codes plus the number of cycles the shown code still owes.
  logic [W-1:0] q[$];
  bit           holding = 0;
  int           left = 0;
  logic [W-1:0] m_io_out = '1;
  logic [W-1:0] m_oeb = '1;
  logic [7:0]   m_shown = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit do_push, do_pop;
    if (rst) begin
      q.delete();
      holding  = 0;
      left     = 0;
      m_io_out = '1;
      m_oeb    = '1;
      m_shown  = '0;
    end else begin
      m_oeb   = {W{~enable}};
      do_push = code_valid && (q.size() < D) && !flush;
      do_pop  = (q.size() != 0) && (!holding || left == 1);
      if (flush) begin
        q.delete();
        holding = 0;
      end else if (do_pop) begin
        m_io_out = q.pop_front();
        m_shown  = m_shown + 8'd1;
        holding  = 1;
        left     = HOLD;
      end else if (holding) begin
        if (left == 1) holding = 0;
        else           left--;
      end
      if (do_push) q.push_back(code_data);
    end
  endtask

  task automatic compare();
    check("io_out",      32'(io_out),      32'(m_io_out));
    check("io_oeb",      32'(io_oeb),      32'(m_oeb));
    check("code_ready",  32'(code_ready),  32'(q.size() < D));
    check("busy",        32'(busy),        32'(holding || q.size() != 0));
    check("shown_count", 32'(shown_count), 32'(m_shown));
  endtask

  // One clock edge: update the model from the pre-edge inputs, then compare after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic push_code(input logic [W-1:0] c);
    bit acc;
    bit done;
    done       = 0;
    code_valid = 1'b1;
    code_data  = c;
    for (int n = 0; n < 400 && !done; n++) begin
      acc = code_ready;
      step();
      if (acc) done = 1;
    end
    code_valid = 1'b0;
    if (!done) check("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 0;
    for (int n = 0; n < budget && !idle; n++) begin
      if (!busy) idle = 1;
      else step();
    end
    if (!busy) idle = 1;
    check("idle_timeout", 32'(idle), 32'd1);
  endtask

  initial begin
    logic [W-1:0] first_code;
    logic [7:0]   shown_before;

    // Reset held for three cycles.
    repeat (3) step();
    check("rst_io_out", 32'(io_out),      32'h1f);
    check("rst_io_oeb", 32'(io_oeb),      32'h1f);
    check("rst_ready",  32'(code_ready),  32'd1);
    check("rst_shown",  32'(shown_count), 32'd0);
    check("rst_busy",   32'(busy),        32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    step();

    // Single code: one-cycle latency, held 64 cycles.
    code_valid = 1'b1;
    code_data  = 5'b00000;
    step();
    code_valid = 1'b0;
    check("single_pre_io_out", 32'(io_out), 32'h1f);
    check("single_pre_busy",   32'(busy),   32'd1);
    step();
    check("single_io_out", 32'(io_out),      32'h00);
    check("single_io_oeb", 32'(io_oeb),      32'h00);
    check("single_shown",  32'(shown_count), 32'd1);
    repeat (HOLD - 1) step();
    check("single_busy_held", 32'(busy), 32'd1);
    step();
    check("single_busy_done", 32'(busy),   32'd0);
    check("single_io_kept",   32'(io_out), 32'h00);

    // Back-to-back sequence: each code visible exactly HOLD cycles.
    push_code(5'b00000);
    push_code(5'b00010);
    push_code(5'b00001);
    repeat (62) step();
    check("seq_c0_end",   32'(io_out), 32'h00);
    step();
    check("seq_c1_start", 32'(io_out), 32'h02);
    repeat (63) step();
    check("seq_c1_end",   32'(io_out), 32'h02);
    step();
    check("seq_c2_start", 32'(io_out), 32'h01);
    repeat (64) step();
    check("seq_busy_done", 32'(busy),        32'd0);
    check("seq_shown",     32'(shown_count), 32'd4);

    // Backpressure: six codes into a four-entry FIFO.
    for (int i = 0; i < 6; i++) begin
      push_code(W'(5'h10 + i));
      if (i == 4) check("bp_ready_low", 32'(code_ready), 32'd0);
    end
    wait_idle(1000);
    check("bp_last_code", 32'(io_out),      32'h15);
    check("bp_shown",     32'(shown_count), 32'd10);

    // Flush mid-hold with three queued and a simultaneous push.
    first_code = 5'h0a;
    push_code(first_code);
    push_code(5'h0b);
    push_code(5'h0c);
    push_code(5'h0d);
    repeat (5) step();
    shown_before = shown_count;
    flush      = 1'b1;
    code_valid = 1'b1;
    code_data  = 5'h0e;
    step();
    flush      = 1'b0;
    code_valid = 1'b0;
    check("flush_busy",   32'(busy),        32'd0);
    check("flush_io_out", 32'(io_out),      32'(first_code));
    check("flush_shown",  32'(shown_count), 32'(shown_before));
    check("flush_ready",  32'(code_ready),  32'd1);
    repeat (5) step();
    check("flush_io_kept", 32'(io_out), 32'(first_code));
    check("flush_idle",    32'(busy),   32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      code_valid = ($urandom_range(0, 1) == 1);
      code_data  = W'($urandom);
      flush      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      step();
    end
    code_valid = 1'b0;
    flush      = 1'b0;
    enable     = 1'b1;

    // Counter wrap: 257 presentations from reset leave the count at 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 257; i++) push_code(W'(i));
    wait_idle(1000);
    check("wrap_shown", 32'(shown_count), 32'd1);

    // Reset mid-hold with FIFO non-empty.
    push_code(5'h03);
    push_code(5'h04);
    push_code(5'h05);
    repeat (10) step();
    rst = 1'b1;
    step();
    check("rst2_io_out", 32'(io_out),      32'h1f);
    check("rst2_io_oeb", 32'(io_oeb),      32'h1f);
    check("rst2_ready",  32'(code_ready),  32'd1);
    check("rst2_busy",   32'(busy),        32'd0);
    check("rst2_shown",  32'(shown_count), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_status_port.md
# test_status_port

User-area output stage that carries test-progress codes from the Elpis-Light core to the Caravel user I/O pads that the external test bench monitors. Codes are offered over a valid/ready handshake, buffered in a small FIFO, and each one is driven on a 5-bit pad group for a guaranteed minimum hold time, so the off-chip monitor cannot miss a transition. Sits between the core's status source and `io_out`/`io_oeb` bits [24:20] of the user project wrapper.

## Interface
Parameters:
- `WIDTH`, 5: code width in bits (one per pad).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `HOLD_CYCLES`, 64: minimum cycles each code is driven (≥2).

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset; synchronous, active-high.
- `enable`  in  1  1 = pads driven, 0 = pads tri-stated (logic keeps running).
- `flush`  in  1  one-cycle pulse: discard FIFO contents, abort current hold.
- `code_valid`  in  1  producer offers `code_data`.
- `code_data`  in  WIDTH  status code.
- `code_ready`  out  1  FIFO can accept this cycle.
- `io_out`  out  WIDTH  code driven to pads.
- `io_oeb`  out  WIDTH  pad output-enable, active-low.
- `busy`  out  1  hold in progress or FIFO non-empty.
- `shown_count`  out  8  number of codes presented; wraps 255→0.

## Operation
- Reset values: `io_out` = all ones (idle marker; all-zeros is reserved as a "test started" code and must not appear at reset), `io_oeb` = all ones, `code_ready` = 1, `busy` = 0, `shown_count` = 0, FIFO empty, FSM in IDLE.
- `io_oeb` = {WIDTH{~enable}}, registered.
- Accept: transfer on edge where `code_valid & code_ready`. `code_ready` = ~full, from registered FIFO occupancy (no combinational path from `code_valid`).
- FIFO: occupancy 0..DEPTH, read/write pointers wrap modulo DEPTH. Push and pop on same edge allowed whenever not full; occupancy unchanged. Push while full impossible (ready low).
- FSM:
  - IDLE: if FIFO non-empty → pop head, load `io_out`, load hold counter with HOLD_CYCLES-1, increment `shown_count`, go HOLD.
  - HOLD: decrement counter each cycle. When counter = 0: if FIFO non-empty, pop and load next code immediately (stay HOLD, reload counter, increment count); else go IDLE.
- `io_out` keeps last presented code indefinitely in IDLE.
- Duplicate consecutive codes are each presented and counted; pads show no transition.
- `flush`: empties FIFO, forces IDLE, `io_out` and `shown_count` unchanged. A push on the same edge as `flush` is discarded. `flush` has priority over pop.
- `wb_rst_i` mid-hold or with FIFO non-empty: all state returns to reset values on that edge.
- `busy` = (state == HOLD) | FIFO non-empty.

## Timing
- Empty FIFO, IDLE: code accepted at edge E0 appears on `io_out` after edge E1 (1-cycle latency).
- Each code is driven exactly HOLD_CYCLES cycles when a successor is queued; back-to-back codes are spaced exactly HOLD_CYCLES cycles.
- `code_ready` rises the cycle after the pop that frees a full FIFO.
- `enable` → `io_oeb` latency 1 cycle.

## Test plan
- Reset: hold `wb_rst_i` 3 cycles → `io_out`=5'b11111, `io_oeb`=5'b11111, `code_ready`=1, `shown_count`=0.
- Single code: enable=1, push 5'b00000 at E0 → `io_out`=00000 after E1, `io_oeb`=00000, `busy` drops after 64 cycles, `io_out` stays 00000.
- Sequence 00000,00010,00001 pushed back-to-back → each visible exactly 64 cycles, in order, `shown_count`=3; external monitor sees all three transitions.
- Backpressure: push 6 codes with DEPTH=4 → `code_ready` low once 4 queued (1 in hold), remaining codes accepted as entries drain, no loss, order preserved.
- Flush mid-hold with 3 queued plus simultaneous push → FIFO empty, IDLE next cycle, pushed code dropped, `io_out` unchanged, `shown_count` unchanged.
- Wrap: present 257 codes with HOLD_CYCLES=2 → `shown_count`=1; reset asserted mid-hold → all outputs at reset values next cycle.
